// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared sizes and types for the fft_frame_ctrl frame sequencer.
package fft_ctrl_pkg;

    localparam int unsigned NBITS      = 10;             // input component width
    localparam int unsigned NBITS_OUT  = 19;             // output component width
    localparam int unsigned N          = 128;            // FFT points
    localparam int unsigned BPF        = N / 4;          // beats per frame
    localparam int unsigned CNT_W      = $clog2(BPF);
    localparam int unsigned LANE_W     = 2 * NBITS;      // {re,im} at the FFT input
    localparam int unsigned LANE_OUT_W = 2 * NBITS_OUT;  // {re,im} at the FFT output

    typedef enum logic [1:0] {IDLE, RUN, PAD} state_e;

    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } tag_t;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: source beat stream (valid/ready) and tagged result stream.
interface fft_frame_ctrl_if;
    import fft_ctrl_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [LANE_W-1:0]     in0_up;
    logic [LANE_W-1:0]     in0_down;
    logic [LANE_W-1:0]     in1_up;
    logic [LANE_W-1:0]     in1_down;

    logic [LANE_OUT_W-1:0] out0_up;
    logic [LANE_OUT_W-1:0] out0_down;
    logic [LANE_OUT_W-1:0] out1_up;
    logic [LANE_OUT_W-1:0] out1_down;
    logic                  out_valid;
    logic                  out_sop;
    logic                  out_eop;
    logic                  out_err;

    // Source and result sink side.
    modport master (
        output in_valid, in0_up, in0_down, in1_up, in1_down,
        input  in_ready,
        input  out0_up, out0_down, out1_up, out1_down,
        input  out_valid, out_sop, out_eop, out_err
    );

    // Controller side.
    modport slave (
        input  in_valid, in0_up, in0_down, in1_up, in1_down,
        output in_ready,
        output out0_up, out0_down, out1_up, out1_down,
        output out_valid, out_sop, out_eop, out_err
    );

endinterface

// File: rtl/fft_tag_delay.sv
// fft_tag_delay: DEPTH x WIDTH shift register with synchronous active-low clear.
module fft_tag_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Advance one stage per clock; a clear empties every stage at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames a 4-lane beat stream into BPF-beat frames for topfft and
// re-tags topfft results after its fixed latency. Underruns are zero-padded and the
// whole frame is flagged with out_err.
// Optional: define FFT_FRAME_STATS_EN to add the frames_done / underruns counters.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned FFT_LAT = 34  // topfft latency, 1..255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    fft_frame_ctrl_if.slave       bus,
    output logic                  fft_rst,
    output logic [LANE_W-1:0]     fft_in0_up,
    output logic [LANE_W-1:0]     fft_in0_down,
    output logic [LANE_W-1:0]     fft_in1_up,
    output logic [LANE_W-1:0]     fft_in1_down,
    input  logic [LANE_OUT_W-1:0] fft_out0_up,
    input  logic [LANE_OUT_W-1:0] fft_out0_down,
    input  logic [LANE_OUT_W-1:0] fft_out1_up,
    input  logic [LANE_OUT_W-1:0] fft_out1_down
`ifdef FFT_FRAME_STATS_EN
    ,
    output logic [15:0]           frames_done,
    output logic [7:0]            underruns
`endif
);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(BPF - 1);
    // Frames in flight between eop at the input and eop at the output, plus one.
    localparam int unsigned      ERR_FIFO_D = (FFT_LAT + BPF - 1) / BPF + 1;
    localparam int unsigned      ERR_CNT_W  = $clog2(ERR_FIFO_D + 1);

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           err_q, err_d;
    tag_t                           tag_q, tag_d, tag_dly;
    logic [3:0][LANE_W-1:0]         in_lanes, lanes_q, lanes_d;
    logic [3:0][LANE_OUT_W-1:0]     res_lanes, out_lanes_q;
    logic                           out_valid_q, out_sop_q, out_eop_q, out_err_q;
    logic                           rel_q, fft_rst_q, running, ready, underrun;
    logic [ERR_FIFO_D-1:0]          fifo_q, fifo_d;
    logic [ERR_CNT_W-1:0]           fcnt_q, fcnt_d;
    logic                           push, pop, frame_err;

    assign in_lanes  = {bus.in0_up, bus.in0_down, bus.in1_up, bus.in1_down};
    assign res_lanes = {fft_out0_up, fft_out0_down, fft_out1_up, fft_out1_down};
    // No beats are taken while topfft is still held in reset.
    assign running   = rst && !fft_rst_q;

    // Hold topfft in reset for one extra clock after rst is released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rel_q     <= 1'b0;
            fft_rst_q <= 1'b1;
        end else begin
            rel_q     <= 1'b1;
            fft_rst_q <= !rel_q;
        end
    end

    // Frame sequencing: next state, beat counter, fft_in beat and its tag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        tag_d    = '0;
        lanes_d  = '0;
        ready    = 1'b0;
        underrun = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = running && enable;
                if (bus.in_valid && ready) begin
                    lanes_d     = in_lanes;
                    tag_d.valid = 1'b1;
                    tag_d.sop   = 1'b1;
                    cnt_d       = CNT_W'(1);
                    state_d     = RUN;
                end
            end
            RUN: begin
                ready = running;
                if (bus.in_valid && ready) begin
                    lanes_d     = in_lanes;
                    tag_d.valid = 1'b1;
                    tag_d.sop   = (cnt_q == '0);
                    tag_d.eop   = (cnt_q == LAST);
                    cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
                    if (cnt_q == LAST && !enable) state_d = IDLE;
                end else if (cnt_q == '0) begin
                    // Gap between back-to-back frames: nothing started yet.
                    state_d = IDLE;
                end else begin
                    underrun    = 1'b1;
                    tag_d.valid = 1'b1;
                    tag_d.eop   = (cnt_q == LAST);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        err_d   = 1'b1;
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                tag_d.valid = 1'b1;
                tag_d.eop   = (cnt_q == LAST);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready = ready;

    // Sequencer state and the registered fft_in beat with its tag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
            lanes_q <= lanes_d;
        end
    end

    assign fft_rst      = fft_rst_q;
    assign fft_in0_up   = lanes_q[3];
    assign fft_in0_down = lanes_q[2];
    assign fft_in1_up   = lanes_q[1];
    assign fft_in1_down = lanes_q[0];

    fft_tag_delay #(
        .DEPTH (FFT_LAT),
        .WIDTH ($bits(tag_t))
    ) u_tag_delay (
        .clk (clk),
        .rst (rst),
        .d   (tag_q),
        .q   (tag_dly)
    );

    // A frame's err is only known at its eop; it is queued per frame and read while the
    // frame drains out. This relies on FFT_LAT >= BPF-1 so the bit lands before the sop.
    assign frame_err = err_q | underrun;
    assign push      = tag_d.eop;
    assign pop       = tag_dly.valid && tag_dly.eop;

    // Per-frame err FIFO: head at bit 0, pop shifts down, push fills the first free slot.
    always_comb begin
        fifo_d = fifo_q;
        fcnt_d = fcnt_q;
        if (pop) begin
            fifo_d = fifo_q >> 1;
            fcnt_d = fcnt_q - ERR_CNT_W'(1);
        end
        if (push) begin
            for (int i = 0; i < int'(ERR_FIFO_D); i++) begin
                if (i == int'(fcnt_d)) fifo_d[i] = frame_err;
            end
            fcnt_d = fcnt_d + ERR_CNT_W'(1);
        end
    end

    // Err FIFO storage and the registered, tagged result lanes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_q      <= '0;
            fcnt_q      <= '0;
            out_lanes_q <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            fcnt_q      <= fcnt_d;
            out_lanes_q <= tag_dly.valid ? res_lanes : '0;
            out_valid_q <= tag_dly.valid;
            out_sop_q   <= tag_dly.valid && tag_dly.sop;
            out_eop_q   <= tag_dly.valid && tag_dly.eop;
            out_err_q   <= tag_dly.valid && fifo_q[0];
        end
    end

    assign bus.out0_up   = out_lanes_q[3];
    assign bus.out0_down = out_lanes_q[2];
    assign bus.out1_up   = out_lanes_q[1];
    assign bus.out1_down = out_lanes_q[0];
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_err   = out_err_q;

`ifdef FFT_FRAME_STATS_EN
    logic [15:0] frames_q;
    logic [7:0]  underruns_q;

    // Completed-frame count (wrapping) and underrun count (saturating).
    always_ff @(posedge clk) begin
        if (!rst) begin
            frames_q    <= '0;
            underruns_q <= '0;
        end else begin
            if (pop) frames_q <= frames_q + 16'd1;
            if (underrun && underruns_q != 8'hFF) underruns_q <= underruns_q + 8'd1;
        end
    end

    assign frames_done = frames_q;
    assign underruns   = underruns_q;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed and random beat streams against a frame-level model.
module tb_fft_frame_ctrl;

    localparam int LAT  = 34;
    localparam int BPF  = 32;
    localparam int OFF  = LAT + 2;  // accept cycle to result cycle
    localparam int MAXC = 4200;

    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic        err;
        logic [79:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fft_rst;
    logic [19:0] fft_in0_up, fft_in0_down, fft_in1_up, fft_in1_down;
    logic [37:0] fft_out0_up, fft_out0_down, fft_out1_up, fft_out1_down;
`ifdef FFT_FRAME_STATS_EN
    logic [15:0] frames_done;
    logic [7:0]  underruns;
`endif

    fft_frame_ctrl_if bus ();

    fft_frame_ctrl #(
        .FFT_LAT (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .bus           (bus),
        .fft_rst       (fft_rst),
        .fft_in0_up    (fft_in0_up),
        .fft_in0_down  (fft_in0_down),
        .fft_in1_up    (fft_in1_up),
        .fft_in1_down  (fft_in1_down),
        .fft_out0_up   (fft_out0_up),
        .fft_out0_down (fft_out0_down),
        .fft_out1_up   (fft_out1_up),
        .fft_out1_down (fft_out1_down)
`ifdef FFT_FRAME_STATS_EN
        ,
        .frames_done   (frames_done),
        .underruns     (underruns)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for topfft: a fixed LAT-clock delay with a recognisable lane mapping.
    function automatic logic [37:0] fake_fft(input logic [19:0] x);
        return {9'h1A5, x[19:10], 9'h0C3, x[9:0]};
    endfunction

    logic [79:0] fin_all;
    logic [79:0] core_pipe [LAT];
    assign fin_all = {fft_in0_up, fft_in0_down, fft_in1_up, fft_in1_down};

    always @(posedge clk) begin
        core_pipe[0] <= fin_all;
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end

    assign fft_out0_up   = fake_fft(core_pipe[LAT-1][79:60]);
    assign fft_out0_down = fake_fft(core_pipe[LAT-1][59:40]);
    assign fft_out1_up   = fake_fft(core_pipe[LAT-1][39:20]);
    assign fft_out1_down = fake_fft(core_pipe[LAT-1][19:0]);

    // Reference model state (frame position terms, not controller encoding).
    beat_t       exp_q [MAXC];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          since_rel = 0;
    bit          in_frame = 0, padding = 0, armed = 0;
    int          pos = 0, fstart = 0;
    int          frames_exp = 0, under_exp = 0;
    logic [79:0] fin_exp = '0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    endtask

    function automatic logic [79:0] rnd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    // One clock: drive inputs, predict the edge, then check what the DUT shows after it.
    task automatic tick(input bit r, input bit en, input bit v, input logic [79:0] data);
        bit          exp_ready;
        beat_t       nb;
        beat_t       e;
        logic [151:0] want_lanes;
        rst = r;
        enable = en;
        bus.in_valid = v;
        {bus.in0_up, bus.in0_down, bus.in1_up, bus.in1_down} = data;
        #1;
        exp_ready = r && since_rel >= 2 && !padding && (in_frame || armed || en);
        check("in_ready", 160'(bus.in_ready), 160'(exp_ready));
        nb = '0;
        if (!r) begin
            in_frame = 0; padding = 0; armed = 0; pos = 0; since_rel = 0;
            frames_exp = 0; under_exp = 0;
            for (int k = cyc + 1; k <= cyc + OFF; k++) exp_q[k] = '0;
        end else begin
            if (since_rel < 2) since_rel++;
            if (in_frame) begin
                nb.valid = 1'b1;
                if (!padding) begin
                    if (v) nb.data = data;
                    else begin
                        padding = 1;
                        if (under_exp < 255) under_exp++;
                    end
                end
                nb.eop = (pos == BPF - 1);
                pos++;
            end else if (v && exp_ready) begin
                nb.valid = 1'b1; nb.sop = 1'b1; nb.data = data;
                in_frame = 1; pos = 1; fstart = cyc; armed = 0;
            end else begin
                armed = 0;
            end
            exp_q[cyc + OFF] = nb;
            if (nb.eop) begin
                for (int k = fstart; k <= cyc; k++) exp_q[k + OFF].err = padding;
                armed = en && !padding;
                in_frame = 0; padding = 0; pos = 0;
            end
        end
        fin_exp = nb.data;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e = exp_q[cyc];
        check("fft_rst", 160'(fft_rst), 160'(since_rel < 2));
        check("fft_in", 160'(fin_all), 160'(fin_exp));
        check("out_tag", 160'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_err}),
              160'({e.valid, e.sop, e.eop, e.err}));
        want_lanes = e.valid ? {fake_fft(e.data[79:60]), fake_fft(e.data[59:40]),
                                fake_fft(e.data[39:20]), fake_fft(e.data[19:0])} : '0;
        check("out_lanes", 160'({bus.out0_up, bus.out0_down, bus.out1_up, bus.out1_down}),
              160'(want_lanes));
`ifdef FFT_FRAME_STATS_EN
        if (e.valid && e.eop) frames_exp++;
        check("frames_done", 160'(frames_done), 160'(frames_exp % 65536));
        check("underruns", 160'(underruns), 160'(under_exp));
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        for (int k = 0; k < MAXC; k++) exp_q[k] = '0;
        rst = 1'b0;
        enable = 1'b1;
        bus.in_valid = 1'b0;
        {bus.in0_up, bus.in0_down, bus.in1_up, bus.in1_down} = '0;
        @(negedge clk);

        // Reset release.
        repeat (3) tick(1'b0, 1'b1, 1'b0, '0);
        repeat (4) tick(1'b1, 1'b1, 1'b0, '0);

        // Single frame, lane0 re = beat index.
        for (int i = 0; i < BPF; i++) tick(1'b1, 1'b1, 1'b1, {10'(i), 70'b0});
        idle(OFF + 9);

        // Back-to-back frames.
        for (int i = 0; i < 2 * BPF; i++) tick(1'b1, 1'b1, 1'b1, rnd());
        idle(OFF + 9);

        // Underrun at beat 10 with a late valid during padding, then a clean frame.
        for (int i = 0; i < BPF; i++) tick(1'b1, 1'b1, (i < 10) || (i >= 15 && i < 18), rnd());
        for (int i = 0; i < BPF; i++) tick(1'b1, 1'b1, 1'b1, rnd());
        idle(OFF + 9);

        // Enable drop at beat 5; source keeps offering beats afterwards.
        for (int i = 0; i < BPF + 10; i++) tick(1'b1, i < 5, 1'b1, rnd());
        idle(OFF + 9);

        // Reset at beat 20, then a normal frame.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b1, rnd());
        tick(1'b0, 1'b1, 1'b1, rnd());
        tick(1'b0, 1'b1, 1'b0, '0);
        repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < BPF; i++) tick(1'b1, 1'b1, 1'b1, {10'(i), 70'b0});
        idle(OFF + 9);

        // Random traffic with rare resets.
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(399, 0) != 0, $urandom_range(7, 0) != 0,
                 $urandom_range(9, 0) != 0, rnd());
        end
        idle(OFF + 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
